// File: rtl/spi_pkg.sv
// spi_pkg: shared definitions for the SPI master.
//   spi_state_e  transfer sequencer states
//   MAX_LEN      widest frame in bits
//   LEN_W        width of the frame length field (0 encodes MAX_LEN)
//   CNT_W        width of bit counters, wide enough to hold MAX_LEN itself
//   frame_bits() maps the length field to a bit count, 0 -> 32
package spi_pkg;

    localparam int MAX_LEN = 32;
    localparam int LEN_W   = 5;
    localparam int CNT_W   = 6;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEAD  = 3'd1,
        XFER  = 3'd2,
        TRAIL = 3'd3,
        DONE  = 3'd4
    } spi_state_e;

    function automatic logic [CNT_W-1:0] frame_bits(input logic [LEN_W-1:0] len);
        logic [CNT_W-1:0] n;
        if (len == 5'd0) begin
            n = 6'd32;
        end else begin
            n = {1'b0, len};
        end
        return n;
    endfunction

endpackage

// File: rtl/spi_clkgen.sv
// spi_clkgen: half-period timer and serial clock generator.
//   clk, rst   system clock, synchronous active-high reset
//   load       restart the timer, latch divider, force sclk low
//   run        count half periods; when low the timer and sclk sit at zero
//   hold_low   at half-period expiry keep sclk low instead of raising it
//   divider    half period is divider+1 clk cycles
//   half_stb   half period expires this cycle
//   rise_stb   sclk rises on the coming edge
//   fall_stb   sclk falls on the coming edge
//   sclk       registered serial clock
module spi_clkgen
    import spi_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             run,
    input  logic             hold_low,
    input  logic [DIV_W-1:0] divider,
    output logic             half_stb,
    output logic             rise_stb,
    output logic             fall_stb,
    output logic             sclk
);

    logic [DIV_W-1:0] div_r;
    logic [DIV_W-1:0] cnt_r;
    logic             sclk_r;
    logic             half_s;

    // Strobes are decoded from current state so the FSM acts on the same edge as sclk.
    always_comb begin
        half_s   = run && (cnt_r == div_r);
        half_stb = half_s;
        rise_stb = half_s && !sclk_r && !hold_low;
        fall_stb = half_s && sclk_r;
    end

    // Half-period counter, latched divider and serial clock register.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_r  <= '0;
            cnt_r  <= '0;
            sclk_r <= 1'b0;
        end else if (load) begin
            div_r  <= divider;
            cnt_r  <= '0;
            sclk_r <= 1'b0;
        end else if (run) begin
            if (half_s) begin
                cnt_r <= '0;
                if (rise_stb) begin
                    sclk_r <= 1'b1;
                end else if (fall_stb) begin
                    sclk_r <= 1'b0;
                end else begin
                    sclk_r <= sclk_r;
                end
            end else begin
                cnt_r  <= cnt_r + DIV_W'(1);
                sclk_r <= sclk_r;
            end
        end else begin
            cnt_r  <= '0;
            sclk_r <= 1'b0;
        end
    end

    assign sclk = sclk_r;

endmodule

// File: rtl/spi_master_core.sv
// spi_master_core: mode-0, MSB-first SPI master, 1..32-bit frames.
//   clk, rst   system clock, synchronous active-high reset
//   start      request a transfer (ignored while busy)
//   len        frame length in bits, 0 means 32; latched at start
//   divider    sclk half period = divider+1 clk cycles; latched at start
//   tx_data    frame to send, bit len-1 first; latched at start
//   rx_data    received frame, right-aligned, updated in the done cycle
//   busy       transfer in progress (LEAD, XFER, TRAIL)
//   done       one-cycle completion pulse
//   ss_o       slave select, active low
//   sclk_o     serial clock, idles low
//   mosi_o     serial data out, changes with sclk falling
//   miso_i     serial data in, sampled on the edge that raises sclk
module spi_master_core #(
    parameter int MAX_LEN = spi_pkg::MAX_LEN,
    parameter int DIV_W   = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [spi_pkg::LEN_W-1:0] len,
    input  logic [DIV_W-1:0]          divider,
    input  logic [MAX_LEN-1:0]        tx_data,
    output logic [MAX_LEN-1:0]        rx_data,
    output logic                      busy,
    output logic                      done,
    output logic                      ss_o,
    output logic                      sclk_o,
    output logic                      mosi_o,
    input  logic                      miso_i
);
    import spi_pkg::*;

    localparam logic [CNT_W-1:0] MAX_LEN_C = CNT_W'(MAX_LEN);

    spi_state_e         state_r;
    spi_state_e         state_n;
    logic [CNT_W-1:0]   n_r;
    logic [CNT_W-1:0]   bit_cnt_r;
    logic [CNT_W-1:0]   n_s;
    logic [CNT_W-1:0]   shamt_s;
    logic [MAX_LEN-1:0] tx_sh_r;
    logic [MAX_LEN-1:0] rx_sh_r;
    logic [MAX_LEN-1:0] rx_data_r;
    logic               ss_r;
    logic               busy_r;
    logic               done_r;
    logic               mosi_r;
    logic               load_s;
    logic               run_s;
    logic               hold_s;
    logic               all_bits_s;
    logic               last_fall_s;
    logic               active_n_s;
    logic               half_stb_s;
    logic               rise_stb_s;
    logic               fall_stb_s;
    logic               sclk_s;

    // Left-align the frame so its first bit always sits in the MSB of the shifter.
    assign n_s         = frame_bits(len);
    assign shamt_s     = MAX_LEN_C - n_s;
    // Once every falling edge has happened the low half still runs out before TRAIL.
    assign all_bits_s  = (bit_cnt_r == n_r);
    assign last_fall_s = fall_stb_s && (bit_cnt_r == (n_r - 6'd1));

    spi_clkgen #(
        .DIV_W (DIV_W)
    ) u_clkgen (
        .clk      (clk),
        .rst      (rst),
        .load     (load_s),
        .run      (run_s),
        .hold_low (hold_s),
        .divider  (divider),
        .half_stb (half_stb_s),
        .rise_stb (rise_stb_s),
        .fall_stb (fall_stb_s),
        .sclk     (sclk_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Next-state and clock generator control.
    always_comb begin
        state_n = state_r;
        load_s  = 1'b0;
        run_s   = 1'b0;
        hold_s  = 1'b0;
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    load_s  = 1'b1;
                    state_n = LEAD;
                end else begin
                    state_n = IDLE;
                end
            end
            LEAD: begin
                run_s = 1'b1;
                if (rise_stb_s) begin
                    state_n = XFER;
                end else begin
                    state_n = LEAD;
                end
            end
            XFER: begin
                run_s  = 1'b1;
                hold_s = all_bits_s;
                if (half_stb_s && all_bits_s) begin
                    state_n = TRAIL;
                end else begin
                    state_n = XFER;
                end
            end
            TRAIL: begin
                run_s  = 1'b1;
                hold_s = 1'b1;
                if (half_stb_s) begin
                    state_n = DONE;
                end else begin
                    state_n = TRAIL;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign active_n_s = (state_n == LEAD) || (state_n == XFER) || (state_n == TRAIL);

    // Frame length, bit counter and the tx/rx shifters.
    always_ff @(posedge clk) begin
        if (rst) begin
            n_r       <= '0;
            bit_cnt_r <= '0;
            tx_sh_r   <= '0;
            rx_sh_r   <= '0;
        end else if (load_s) begin
            n_r       <= n_s;
            bit_cnt_r <= '0;
            tx_sh_r   <= tx_data << shamt_s;
            rx_sh_r   <= '0;
        end else begin
            if (rise_stb_s) begin
                rx_sh_r <= {rx_sh_r[MAX_LEN-2:0], miso_i};
            end
            if (fall_stb_s) begin
                bit_cnt_r <= bit_cnt_r + 6'd1;
                tx_sh_r   <= {tx_sh_r[MAX_LEN-2:0], 1'b0};
            end
        end
    end

    // Registered pin and status outputs, derived from the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            ss_r      <= 1'b1;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            mosi_r    <= 1'b0;
            rx_data_r <= '0;
        end else begin
            ss_r   <= !active_n_s;
            busy_r <= active_n_s;
            done_r <= (state_n == DONE);
            if (state_n == DONE) begin
                rx_data_r <= rx_sh_r;
            end
            if (load_s) begin
                mosi_r <= (tx_data << shamt_s) >> (MAX_LEN - 1);
            end else if (fall_stb_s && !last_fall_s) begin
                mosi_r <= tx_sh_r[MAX_LEN-2];
            end else if (state_n == DONE) begin
                mosi_r <= 1'b0;
            end
        end
    end

    assign ss_o    = ss_r;
    assign busy    = busy_r;
    assign done    = done_r;
    assign mosi_o  = mosi_r;
    assign sclk_o  = sclk_s;
    assign rx_data = rx_data_r;

endmodule

// File: doc/spi_master_core.md
# spi_master_core

Synthesizable SPI master that drives the team's SPI slave: it asserts slave select, generates the serial clock, shifts a 1–32-bit frame out on `mosi_o`, and captures `miso_i` into a parallel word. It sits directly upstream of the slave, between a register/host interface (start, tx word, status) and the SPI pins. The mode is fixed at 0: `sclk` idles low, the master launches MOSI after falling edges, and samples MISO on rising edges. Bits are sent and received MSB-first.

## Interface
- `MAX_LEN`, 32: widest frame in bits; sets the width of the data ports.
- `DIV_W`, 8: width of the clock divider input.

- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  request a transfer; accepted only when `busy`=0.
- `len`  in  5  frame length in bits; 0 means 32. Latched at start.
- `divider`  in  DIV_W  half-period of `sclk` in `clk` cycles is `divider`+1. Latched at start.
- `tx_data`  in  MAX_LEN  frame to send; bit `len`-1 goes out first. Latched at start.
- `rx_data`  out  MAX_LEN  received frame, right-aligned; held until the next `done`.
- `busy`  out  1  high from the cycle after start is accepted through the last TRAIL cycle.
- `done`  out  1  one-cycle pulse when the transfer completes.
- `ss_o`  out  1  slave select, active low.
- `sclk_o`  out  1  serial clock.
- `mosi_o`  out  1  master out, slave in.
- `miso_i`  in  1  master in, slave out.

## Operation
- Reset values: `ss_o`=1, `sclk_o`=0, `mosi_o`=0, `busy`=0, `done`=0, `rx_data`=0, state IDLE, all counters 0.
- Let H = `divider`+1 and N = `len`, with 0 mapped to 32.
- States:
  - **IDLE**: on `start`, latch `len`, `divider` and `tx_data`; go to LEAD.
  - **LEAD**: `ss_o`=0 and `mosi_o` = first bit, held for H cycles; go to XFER.
  - **XFER**: N bit periods. Each period is `sclk_o` high for H cycles, then low for H cycles.
    - On each 0→1 clock edge, shift `miso_i` (its value at that `clk` edge) into the rx shifter.
    - On each 1→0 clock edge except the last, advance `mosi_o` to the next bit.
    - After the Nth falling edge, go to TRAIL.
  - **TRAIL**: `sclk_o`=0 and `ss_o`=0 for H cycles; go to DONE.
  - **DONE**: one cycle with `ss_o`=1, `done`=1, `busy`=0, and `rx_data` updated; go to IDLE.
- `start` while `busy`=1 is ignored, with no queuing.
- `start` in the DONE cycle is accepted as if in IDLE; LEAD begins on the next cycle.
- Bits of `rx_data` above position N-1 are zero.
- `rst` mid-transfer: on the next edge all outputs return to reset values. No `done` is issued and `rx_data` is cleared.

## Timing
- Start accepted at edge 0. At edge 1: `ss_o`=0, `busy`=1, `mosi_o`=`tx_data`[N-1].
- First `sclk_o` rise is at edge 1+H.
- `done` is high in the cycle beginning at edge 1 + (2N+2)·H.
- Example: N=32, `divider`=0 gives `done` at edge 67.
- MOSI changes coincide with `sclk_o` falling. MISO is sampled on the `clk` edge that raises `sclk_o`.
- No combinational path from any input to any output. All outputs are registered.

## Structure
- Shared package `spi_pkg`: state enum (IDLE, LEAD, XFER, TRAIL, DONE), `MAX_LEN`, `LEN_W`=5, and a helper mapping len 0→32.
- Sub-module `spi_clkgen`, instantiated once: a half-period counter with load and `divider` input.
  - Outputs: `rise_stb` and `fall_stb` one-cycle strobes, plus the registered `sclk`.
  - The core FSM owns the bit counter and the shifters.

## Test plan
- **Basic frame:** `divider`=0, `len`=0, `tx_data`=0xA5A5_0F0F against the slave model preloaded to 0x1234_5678.
  - Slave receives 0xA5A5_0F0F.
  - `rx_data`=0x1234_5678.
  - `done` at edge 67 and `sclk_o` shows exactly 32 rises.
- **Short frame:** `len`=8, `divider`=3, `tx_data`=0x0000_00C3.
  - MOSI sequence is 1,1,0,0,0,0,1,1.
  - `rx_data`[31:8]=0.
  - `done` at edge 1 + 18·4 = 73.
- **Start while busy:** second `start` mid-XFER is ignored.
  - Exactly one `done`.
  - `tx_data` change mid-transfer does not alter MOSI.
- **Back-to-back:** `start` held high through the DONE cycle.
  - Second LEAD begins on the cycle after `done`.
  - `ss_o` is high for exactly one cycle between frames.
- **Reset mid-XFER:** after 10 bits, `rst`=1 for 1 cycle.
  - Next cycle: `ss_o`=1, `sclk_o`=0, `busy`=0, `rx_data`=0.
  - No `done` pulse.
